// File: rtl/riscv_wb_arbiter_if.sv
// rtl/riscv_wb_arbiter_if.sv - execute/load producer and register-file write port bundle
interface riscv_wb_arbiter_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic [1:0]  ld_offset;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        busy;

  // Arbiter side: consumes both producers, drives the write port.
  modport slave (
    input  ex_valid, ex_rd, ex_data,
    input  ld_valid, ld_rd, ld_data, ld_size, ld_unsigned, ld_offset,
    output ex_ready, ld_ready, we3, a3, wd3, busy
  );

  // Producer / register-file side.
  modport master (
    output ex_valid, ex_rd, ex_data,
    output ld_valid, ld_rd, ld_data, ld_size, ld_unsigned, ld_offset,
    input  ex_ready, ld_ready, we3, a3, wd3, busy
  );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// rtl/riscv_wb_arbiter.sv - merges execute results and formatted loads onto one register write port
module riscv_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  riscv_wb_arbiter_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          we3_q;
  logic [4:0]    a3_q;
  logic [31:0]   wd3_q;

  logic          full, empty, hazard, stall_ex;
  logic          ld_acc, push, pop, bypass, sel;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;
  logic [31:0]   ld_fmt;
  logic [31:0]   byte_sh, half_sh;
  logic [AW-1:0] rel;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Extract the addressed byte/half from the raw word and extend it.
  always_comb begin
    byte_sh = bus.ld_data >> {bus.ld_offset, 3'b000};
    half_sh = bus.ld_data >> {bus.ld_offset[1], 4'b0000};
    ld_fmt  = bus.ld_data;
    case (bus.ld_size)
      2'd0:    ld_fmt = bus.ld_unsigned ? {24'b0, byte_sh[7:0]}
                                        : {{24{byte_sh[7]}}, byte_sh[7:0]};
      2'd1:    ld_fmt = bus.ld_unsigned ? {16'b0, half_sh[15:0]}
                                        : {{16{half_sh[15]}}, half_sh[15:0]};
      default: ld_fmt = bus.ld_data;
    endcase
  end

  // An older buffered load to the same rd must retire before the execute write.
  always_comb begin
    hazard = 1'b0;
    rel    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = AW'(i) - rd_ptr_q;
      if (({1'b0, rel} < count_q) && (fifo_rd_q[i] == bus.ex_rd))
        hazard = 1'b1;
    end
    hazard = hazard && bus.ex_valid && (bus.ex_rd != 5'd0);
  end

  assign stall_ex     = full || hazard;
  assign bus.ex_ready = !rst && !stall_ex;
  assign bus.ld_ready = !rst && !full;
  assign ld_acc       = bus.ld_valid && bus.ld_ready;

  // Priority pick of the single write-port user for this cycle.
  always_comb begin
    pop      = 1'b0;
    bypass   = 1'b0;
    sel      = 1'b0;
    sel_rd   = fifo_rd_q[rd_ptr_q];
    sel_data = fifo_data_q[rd_ptr_q];
    if (stall_ex) begin
      pop = 1'b1;
      sel = 1'b1;
    end else if (bus.ex_valid) begin
      sel      = 1'b1;
      sel_rd   = bus.ex_rd;
      sel_data = bus.ex_data;
    end else if (!empty) begin
      pop = 1'b1;
      sel = 1'b1;
    end else if (ld_acc) begin
      bypass   = 1'b1;
      sel      = 1'b1;
      sel_rd   = bus.ld_rd;
      sel_data = ld_fmt;
    end
  end

  assign push = ld_acc && !bypass;

  // FIFO storage; contents are qualified by count so they need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= bus.ld_rd;
      fifo_data_q[wr_ptr_q] <= ld_fmt;
    end
  end

  // Pointers, occupancy and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we3_q    <= 1'b0;
      a3_q     <= 5'd0;
      wd3_q    <= 32'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // x0 slots still consume the source but never enable the write.
      we3_q <= sel && (sel_rd != 5'd0);
      if (sel) begin
        a3_q  <= sel_rd;
        wd3_q <= sel_data;
      end
    end
  end

  assign bus.we3  = we3_q;
  assign bus.a3   = a3_q;
  assign bus.wd3  = wd3_q;
  assign bus.busy = !empty;
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// tb/tb_riscv_wb_arbiter.sv - scoreboard bench for the write-back arbiter
module tb_riscv_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_wb_arbiter_if bus();
  riscv_wb_arbiter #(.DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q[$];

  task automatic idle_inputs();
    bus.ex_valid = 1'b0; bus.ex_rd = 5'd0; bus.ex_data = 32'd0;
    bus.ld_valid = 1'b0; bus.ld_rd = 5'd0; bus.ld_data = 32'd0;
    bus.ld_size = 2'd2; bus.ld_unsigned = 1'b0; bus.ld_offset = 2'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd1; bus.ex_data = 32'h5;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.ex_ready !== 1'b0) begin bad++; $display("FAIL reset_ex_ready got=%b exp=0", bus.ex_ready); end
    total++; if (bus.ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready got=%b exp=0", bus.ld_ready); end
    total++; if (bus.we3 !== 1'b0) begin bad++; $display("FAIL reset_we3 got=%b exp=0", bus.we3); end
    total++; if ({bus.a3, bus.wd3} !== 37'd0) begin bad++; $display("FAIL reset_a3_wd3 got=%h/%h exp=0/0", bus.a3, bus.wd3); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    rst = 1'b0;
    #1;
    total++; if (bus.ex_ready !== 1'b1) begin bad++; $display("FAIL release_ex_ready got=%b exp=1", bus.ex_ready); end
    total++; if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL release_ld_ready got=%b exp=1", bus.ld_ready); end
    bus.ex_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.we3 !== 1'b0) begin bad++; $display("FAIL release_idle_we3 got=%b exp=0", bus.we3); end
  endtask

  task automatic test_bypass();
    logic [1:0]  sz  [3] = '{2'd0, 2'd0, 2'd1};
    logic [1:0]  off [3] = '{2'd2, 2'd1, 2'd2};
    logic        uns [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] expd[3] = '{32'hFFFF_FFFF, 32'h0000_007F, 32'h0000_80FF};
    logic [36:0] e;
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      bus.ld_valid = 1'b1; bus.ld_rd = 5'd5; bus.ld_data = 32'h80FF_7F01;
      bus.ld_size = sz[i]; bus.ld_offset = off[i]; bus.ld_unsigned = uns[i];
      exp_q.push_back({5'd5, expd[i]});
      @(posedge clk); #1;
      idle_inputs();
      total++; if (bus.we3 !== 1'b1) begin bad++; $display("FAIL bypass%0d_we3 got=%b exp=1", i, bus.we3); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bypass%0d_busy got=%b exp=0", i, bus.busy); end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++; if ({bus.a3, bus.wd3} !== e) begin bad++; $display("FAIL bypass%0d_data got=%0d/%h exp=%0d/%h", i, bus.a3, bus.wd3, e[36:32], e[31:0]); end
      end
    end
  endtask

  task automatic test_collision();
    logic [36:0] e;
    idle_inputs();
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd3; bus.ex_data = 32'h11;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd4; bus.ld_data = 32'h22;
    exp_q.push_back({5'd3, 32'h11});
    exp_q.push_back({5'd4, 32'h22});
    #1;
    total++; if ({bus.ex_ready, bus.ld_ready} !== 2'b11) begin bad++; $display("FAIL coll_ready got=%b exp=11", {bus.ex_ready, bus.ld_ready}); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      total++; if (bus.we3 !== 1'b1) begin bad++; $display("FAIL coll%0d_we3 got=%b exp=1", c, bus.we3); end
      total++; if (bus.busy !== (c == 0)) begin bad++; $display("FAIL coll%0d_busy got=%b exp=%b", c, bus.busy, (c == 0)); end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++; if ({bus.a3, bus.wd3} !== e) begin bad++; $display("FAIL coll%0d_data got=%0d/%h exp=%0d/%h", c, bus.a3, bus.wd3, e[36:32], e[31:0]); end
      end
    end
    @(posedge clk); #1;
    total++; if (bus.we3 !== 1'b0) begin bad++; $display("FAIL coll_idle_we3 got=%b exp=0", bus.we3); end
  endtask

  task automatic test_full_fifo();
    int exv [6] = '{1, 1, 1, 1, 0, 0};
    int exrd[6] = '{10, 10, 10, 10, 0, 0};
    int exd [6] = '{'h100, 'h101, 'h102, 'h102, 0, 0};
    int ldv [6] = '{1, 1, 1, 1, 0, 0};
    int ldrd[6] = '{12, 13, 14, 14, 0, 0};
    int ldd [6] = '{'hC1, 'hC2, 'hC3, 'hC3, 0, 0};
    int exr [6] = '{1, 1, 0, 1, 0, 1};
    int ldr [6] = '{1, 1, 0, 1, 0, 1};
    int wa  [6] = '{10, 10, 12, 10, 13, 14};
    int wd  [6] = '{'h100, 'h101, 'hC1, 'h102, 'hC2, 'hC3};
    int bsy [6] = '{1, 1, 1, 1, 1, 0};
    logic [36:0] e;
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      bus.ex_valid = exv[i][0]; bus.ex_rd = 5'(exrd[i]); bus.ex_data = 32'(exd[i]);
      bus.ld_valid = ldv[i][0]; bus.ld_rd = 5'(ldrd[i]); bus.ld_data = 32'(ldd[i]);
      exp_q.push_back({5'(wa[i]), 32'(wd[i])});
      #1;
      total++; if (bus.ex_ready !== exr[i][0]) begin bad++; $display("FAIL full%0d_ex_ready got=%b exp=%0d", i, bus.ex_ready, exr[i]); end
      total++; if (bus.ld_ready !== ldr[i][0]) begin bad++; $display("FAIL full%0d_ld_ready got=%b exp=%0d", i, bus.ld_ready, ldr[i]); end
      @(posedge clk); #1;
      total++; if (bus.we3 !== 1'b1) begin bad++; $display("FAIL full%0d_we3 got=%b exp=1", i, bus.we3); end
      total++; if (bus.busy !== bsy[i][0]) begin bad++; $display("FAIL full%0d_busy got=%b exp=%0d", i, bus.busy, bsy[i]); end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++; if ({bus.a3, bus.wd3} !== e) begin bad++; $display("FAIL full%0d_data got=%0d/%h exp=%0d/%h", i, bus.a3, bus.wd3, e[36:32], e[31:0]); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_hazard();
    int exrd[3] = '{8, 7, 7};
    int exd [3] = '{'h55, 'hBB, 'hBB};
    int ldv [3] = '{1, 0, 0};
    int exr [3] = '{1, 0, 1};
    int wa  [3] = '{8, 7, 7};
    int wd  [3] = '{'h55, 'hAA, 'hBB};
    int bsy [3] = '{1, 0, 0};
    logic [36:0] e;
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      bus.ex_valid = 1'b1; bus.ex_rd = 5'(exrd[i]); bus.ex_data = 32'(exd[i]);
      bus.ld_valid = ldv[i][0]; bus.ld_rd = 5'd7; bus.ld_data = 32'hAA;
      exp_q.push_back({5'(wa[i]), 32'(wd[i])});
      #1;
      total++; if (bus.ex_ready !== exr[i][0]) begin bad++; $display("FAIL haz%0d_ex_ready got=%b exp=%0d", i, bus.ex_ready, exr[i]); end
      @(posedge clk); #1;
      total++; if (bus.we3 !== 1'b1) begin bad++; $display("FAIL haz%0d_we3 got=%b exp=1", i, bus.we3); end
      total++; if (bus.busy !== bsy[i][0]) begin bad++; $display("FAIL haz%0d_busy got=%b exp=%0d", i, bus.busy, bsy[i]); end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++; if ({bus.a3, bus.wd3} !== e) begin bad++; $display("FAIL haz%0d_data got=%0d/%h exp=%0d/%h", i, bus.a3, bus.wd3, e[36:32], e[31:0]); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_x0_and_reset();
    logic [36:0] e;
    idle_inputs();
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd0; bus.ex_data = 32'hDEAD;
    #1;
    total++; if (bus.ex_ready !== 1'b1) begin bad++; $display("FAIL x0_ex_ready got=%b exp=1", bus.ex_ready); end
    @(posedge clk); #1;
    idle_inputs();
    total++; if (bus.we3 !== 1'b0) begin bad++; $display("FAIL x0_we3 got=%b exp=0", bus.we3); end
    total++; if ({bus.a3, bus.wd3} !== {5'd0, 32'hDEAD}) begin bad++; $display("FAIL x0_a3_wd3 got=%0d/%h exp=0/0000dead", bus.a3, bus.wd3); end
    for (int i = 0; i < 2; i++) begin
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd9; bus.ex_data = 32'(i + 1);
      bus.ld_valid = 1'b1; bus.ld_rd = 5'(20 + i); bus.ld_data = 32'(32'h201 + i);
      exp_q.push_back({5'd9, 32'(i + 1)});
      @(posedge clk); #1;
      total++; if (bus.we3 !== 1'b1) begin bad++; $display("FAIL fill%0d_we3 got=%b exp=1", i, bus.we3); end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++; if ({bus.a3, bus.wd3} !== e) begin bad++; $display("FAIL fill%0d_data got=%0d/%h exp=%0d/%h", i, bus.a3, bus.wd3, e[36:32], e[31:0]); end
      end
    end
    idle_inputs();
    #1;
    total++; if ({bus.busy, bus.ld_ready} !== 2'b10) begin bad++; $display("FAIL fill_busy_ldready got=%b exp=10", {bus.busy, bus.ld_ready}); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if ({bus.busy, bus.we3} !== 2'b00) begin bad++; $display("FAIL midrst_busy_we3 got=%b exp=00", {bus.busy, bus.we3}); end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++; if ({bus.busy, bus.we3} !== 2'b00) begin bad++; $display("FAIL postrst%0d_busy_we3 got=%b exp=00", c, {bus.busy, bus.we3}); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_bypass();
    test_collision();
    test_full_fifo();
    test_hazard();
    test_x0_and_reset();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
